vram_port_arbiter: RTL and testbench

- Shares one single-port synchronous frame/data RAM between two requesters.
- Requester 1 is the CPU MEM stage: load/store, may be stalled.
- Requester 2 is the display scan-out reader on the same clock: read-only and real-time.
- The display wins by default. A bounded-wait counter guarantees CPU progress.
- The block drives the RAM port, routes read data back to the winner with a 1-cycle tag, and produces the CPU stall.

---
 rtl/vram_port_arbiter.sv | 116 +++++++++++
 tb/tb_vram_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the CPU MEM stage and the
// display scan-out reader; the display wins by default, with a bounded CPU wait.
module vram_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_grant,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_grant,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_DISP = 2'd2
  } rd_tag_e;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]        r_wait_cnt;
  logic [3:0]        w_wait_cnt_nxt;
  rd_tag_e           r_rd_tag;
  rd_tag_e           w_rd_tag_nxt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_disp_rdata;
  logic [CNT_W-1:0]  r_conflict_cnt;
  logic              w_cpu_grant;
  logic              w_disp_grant;
  logic              w_cpu_rvalid;
  logic              w_disp_rvalid;

  // Grant decision and next-state; everything is held off while rst is high.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_cpu_grant    = 1'b0;
    w_disp_grant   = 1'b0;
    w_wait_cnt_nxt = 4'd0;
    w_rd_tag_nxt   = TAG_NONE;
    if (!rst) begin
      if (cpu_req && (!disp_req || r_wait_cnt >= MAX_W)) begin
        w_cpu_grant = 1'b1;
      end else if (disp_req) begin
        w_disp_grant = 1'b1;
      end
    end
    if (cpu_req && !w_cpu_grant) begin
      w_wait_cnt_nxt = (r_wait_cnt >= MAX_W) ? MAX_W : r_wait_cnt + 4'd1;
    end
    if (w_cpu_grant && !cpu_we) begin
      w_rd_tag_nxt = TAG_CPU;
    end else if (w_disp_grant) begin
      w_rd_tag_nxt = TAG_DISP;
    end
  end

  assign w_cpu_rvalid  = (r_rd_tag == TAG_CPU)  && !rst;
  assign w_disp_rvalid = (r_rd_tag == TAG_DISP) && !rst;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_wait_cnt     <= 4'd0;
      r_rd_tag       <= TAG_NONE;
      r_cpu_rdata    <= '0;
      r_disp_rdata   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_rd_tag   <= w_rd_tag_nxt;
      if (w_cpu_rvalid) begin
        r_cpu_rdata <= ram_rdata;
      end
      if (w_disp_rvalid) begin
        r_disp_rdata <= ram_rdata;
      end
      if (cpu_req && disp_req && !(&r_conflict_cnt)) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
    end
  end

  assign cpu_grant    = w_cpu_grant;
  assign disp_grant   = w_disp_grant;
  assign cpu_stall    = cpu_req && !w_cpu_grant;
  assign cpu_rvalid   = w_cpu_rvalid;
  assign disp_rvalid  = w_disp_rvalid;
  // Returned data is visible in its return cycle, then held from the register.
  assign cpu_rdata    = w_cpu_rvalid  ? ram_rdata : r_cpu_rdata;
  assign disp_rdata   = w_disp_rvalid ? ram_rdata : r_disp_rdata;
  assign ram_en       = w_cpu_grant || w_disp_grant;
  assign ram_we       = w_cpu_grant && cpu_we;
  assign ram_addr     = w_cpu_grant ? cpu_addr : disp_addr;
  assign ram_wdata    = cpu_wdata;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: cycle-level arbitration model,
// shadow memory, and a scoreboard of expected read returns.
module tb_vram_port_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_grant;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_grant;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [CNT_W-1:0]  conflict_cnt;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_grant(cpu_grant), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_grant(disp_grant),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  // Behavioural single-port synchronous RAM, 256 words.
  logic [DATA_W-1:0] ram_mem [0:255];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr[7:0]];
    end
  end

  typedef struct {
    logic              is_cpu;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              sb[$];
  logic [DATA_W-1:0] shadow [0:255];
  int                m_wait;
  logic [CNT_W-1:0]  m_conf;
  logic [DATA_W-1:0] m_cpu_rdata;
  logic [DATA_W-1:0] m_disp_rdata;
  int                checks = 0;
  int                failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One normal cycle: drive at negedge, check 1 ns later, then advance the model.
  task automatic cycle(input logic cr, input logic we, input logic [15:0] ca,
                       input logic [31:0] cw, input logic dr, input logic [15:0] da);
    logic exp_cg, exp_dg, exp_crv, exp_drv;
    ret_t r;
    @(negedge clk);
    rst = 1'b0; cpu_req = cr; cpu_we = we; cpu_addr = ca; cpu_wdata = cw;
    disp_req = dr; disp_addr = da;
    #1;
    exp_crv = (sb.size() > 0) && sb[0].is_cpu;
    exp_drv = (sb.size() > 0) && !sb[0].is_cpu;
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
    check("disp_rvalid", 32'(disp_rvalid), 32'(exp_drv));
    if (sb.size() > 0) begin
      r = sb.pop_front();
      if (r.is_cpu) m_cpu_rdata = r.data;
      else          m_disp_rdata = r.data;
    end
    check("cpu_rdata", cpu_rdata, m_cpu_rdata);
    check("disp_rdata", disp_rdata, m_disp_rdata);
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

    exp_cg = cr && (!dr || m_wait == MAX_WAIT);
    exp_dg = dr && !exp_cg;
    check("cpu_grant", 32'(cpu_grant), 32'(exp_cg));
    check("disp_grant", 32'(disp_grant), 32'(exp_dg));
    check("cpu_stall", 32'(cpu_stall), 32'(cr && !exp_cg));
    check("ram_en", 32'(ram_en), 32'(exp_cg || exp_dg));
    check("ram_we", 32'(ram_we), 32'(exp_cg && we));
    if (exp_cg || exp_dg) check("ram_addr", 32'(ram_addr), 32'(exp_cg ? ca : da));
    if (exp_cg && we) check("ram_wdata", ram_wdata, cw);

    if (exp_cg && !we) sb.push_back('{is_cpu: 1'b1, data: shadow[ca[7:0]]});
    if (exp_dg)        sb.push_back('{is_cpu: 1'b0, data: shadow[da[7:0]]});
    if (exp_cg && we)  shadow[ca[7:0]] = cw;
    if (cr && dr && m_conf != '1) m_conf = m_conf + 1'b1;
    if (cr && !exp_cg) m_wait = (m_wait >= MAX_WAIT) ? MAX_WAIT : m_wait + 1;
    else               m_wait = 0;
  endtask

  // One reset cycle with requests held as given: nothing may be granted or returned.
  task automatic reset_cycle(input logic cr, input logic dr);
    @(negedge clk);
    rst = 1'b1; cpu_req = cr; cpu_we = 1'b0; disp_req = dr;
    #1;
    check("rst_cpu_grant", 32'(cpu_grant), 32'd0);
    check("rst_disp_grant", 32'(disp_grant), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
    sb.delete();
    m_wait = 0; m_conf = '0; m_cpu_rdata = '0; m_disp_rdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'hA500_0000 + 32'(i);
      shadow[i]  = 32'hA500_0000 + 32'(i);
    end
    m_wait = 0; m_conf = '0; m_cpu_rdata = '0; m_disp_rdata = '0;

    reset_cycle(1'b1, 1'b1);
    reset_cycle(1'b0, 1'b0);

    // CPU only: store, load back, then load/store same address for read-before-write.
    cycle(1, 1, 16'h0010, 32'hDEADBEEF, 0, 0);
    cycle(1, 0, 16'h0010, 32'h0, 0, 0);
    cycle(0, 0, 16'h0, 32'h0, 0, 0);
    check("cpu_load_deadbeef", cpu_rdata, 32'hDEADBEEF);
    cycle(1, 0, 16'h0010, 32'h0, 0, 0);
    cycle(1, 1, 16'h0010, 32'hCAFEF00D, 0, 0);
    check("rbw_old_data", cpu_rdata, 32'hDEADBEEF);
    cycle(1, 0, 16'h0010, 32'h0, 0, 0);
    cycle(0, 0, 16'h0, 32'h0, 0, 0);
    check("cpu_load_new", cpu_rdata, 32'hCAFEF00D);

    // Display only: streaming reads 0..7.
    for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 32'h0, 1, 16'(i));
    cycle(0, 0, 16'h0, 32'h0, 0, 0);
    check("disp_last", disp_rdata, 32'hA500_0007);

    // Continuous conflict with the CPU address wandering while it loses.
    reset_cycle(0, 0);
    for (int i = 0; i < 12; i++)
      cycle(1, 0, 16'($urandom_range(32, 63)), 32'h0, 1, 16'(64 + i));
    cycle(0, 0, 16'h0, 32'h0, 0, 0);

    // CPU drops out after two losses; fairness history restarts.
    reset_cycle(0, 0);
    cycle(1, 0, 16'h0020, 32'h0, 1, 16'h0001);
    cycle(1, 0, 16'h0020, 32'h0, 1, 16'h0002);
    cycle(0, 0, 16'h0020, 32'h0, 1, 16'h0003);
    for (int i = 0; i < 5; i++) cycle(1, 0, 16'h0021, 32'h0, 1, 16'(4 + i));
    cycle(0, 0, 16'h0, 32'h0, 0, 0);

    // Reset the cycle after a CPU load grant: the return is dropped.
    cycle(1, 0, 16'h0010, 32'h0, 0, 0);
    reset_cycle(1, 0);
    cycle(0, 0, 16'h0, 32'h0, 0, 0);
    check("post_rst_cpu_rdata", cpu_rdata, 32'h0);

    // Conflict counter saturation on the narrow build.
    for (int i = 0; i < 20; i++) cycle(1, 0, 16'h0030, 32'h0, 1, 16'(i));
    cycle(0, 0, 16'h0, 32'h0, 0, 0);
    check("conflict_sat", 32'(conflict_cnt), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
